// File: rtl/n101_expl_axi_mst_pkg.sv
// Shared types and AXI constants for the single-outstanding example AXI master.
package n101_expl_axi_mst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;
    localparam logic [3:0] CACHE_DEFAULT = 4'h0;
    localparam logic [2:0] PROT_DEFAULT  = 3'h0;
    localparam logic [1:0] LOCK_DEFAULT  = 2'h0;
    localparam logic [3:0] LEN_SINGLE    = 4'h0;

    // AxSIZE encoding: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned dw);
        case (dw)
            8:       return 3'b000;
            16:      return 3'b001;
            32:      return 3'b010;
            64:      return 3'b011;
            128:     return 3'b100;
            256:     return 3'b101;
            512:     return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/n101_expl_axi_mst_if.sv
// Command/response and AXI bus bundle; master modport is the DUT view.
interface n101_expl_axi_mst_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    import n101_expl_axi_mst_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          axi_arvalid;
    logic          axi_arready;
    logic [AW-1:0] axi_araddr;
    logic [3:0]    axi_arcache;
    logic [2:0]    axi_arprot;
    logic [1:0]    axi_arlock;
    logic [1:0]    axi_arburst;
    logic [3:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;

    logic          axi_awvalid;
    logic          axi_awready;
    logic [AW-1:0] axi_awaddr;
    logic [3:0]    axi_awcache;
    logic [2:0]    axi_awprot;
    logic [1:0]    axi_awlock;
    logic [1:0]    axi_awburst;
    logic [3:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wlast;
    logic          axi_bvalid;
    logic          axi_bready;
    logic [1:0]    axi_bresp;

    modport master (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output axi_arvalid, axi_araddr, axi_arcache, axi_arprot, axi_arlock,
               axi_arburst, axi_arlen, axi_arsize, axi_rready,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        output axi_awvalid, axi_awaddr, axi_awcache, axi_awprot, axi_awlock,
               axi_awburst, axi_awlen, axi_awsize,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

    modport slave (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  axi_arvalid, axi_araddr, axi_arcache, axi_arprot, axi_arlock,
               axi_arburst, axi_arlen, axi_arsize, axi_rready,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_awvalid, axi_awaddr, axi_awcache, axi_awprot, axi_awlock,
               axi_awburst, axi_awlen, axi_awsize,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

endinterface

// File: rtl/n101_expl_axi_mst.sv
// Single-outstanding AXI master: one valid/ready command becomes one
// single-beat AXI read (AR+R) or write (AW+W+B), answered on the response port.
module n101_expl_axi_mst
    import n101_expl_axi_mst_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    n101_expl_axi_mst_if.master  bus
);

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            ar_done, r_done, aw_done, w_done, b_done;
    logic            arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, rsp_valid_q;
    logic            ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_hs = arvalid_q & bus.axi_arready;
    assign r_hs  = rready_q  & bus.axi_rvalid;
    assign aw_hs = awvalid_q & bus.axi_awready;
    assign w_hs  = wvalid_q  & bus.axi_wready;
    assign b_hs  = bready_q  & bus.axi_bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ar_done     <= 1'b0;
            r_done      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            b_done      <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        wmask_q <= bus.cmd_wmask;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        ar_done <= 1'b0;
                        r_done  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        b_done  <= 1'b0;
                        // Ready is raised together with valid: the coupled slave
                        // only issues arready/wready when rready/bready are high.
                        if (bus.cmd_read) begin
                            state     <= RD;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end else begin
                            state     <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        ar_done   <= 1'b1;
                    end
                    if (r_hs) begin
                        rdata_q <= bus.axi_rdata;
                        err_q   <= bus.axi_rresp[1];
                        r_done  <= 1'b1;
                    end
                    if ((ar_done | ar_hs) & (r_done | r_hs)) begin
                        state       <= RSP;
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (b_hs) begin
                        err_q   <= bus.axi_bresp[1];
                        rdata_q <= '0;
                        b_done  <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs)) begin
                        state       <= RSP;
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;

    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arcache = CACHE_DEFAULT;
    assign bus.axi_arprot  = PROT_DEFAULT;
    assign bus.axi_arlock  = LOCK_DEFAULT;
    assign bus.axi_arburst = BURST_INCR;
    assign bus.axi_arlen   = LEN_SINGLE;
    assign bus.axi_arsize  = axi_size(DW);
    assign bus.axi_rready  = rready_q;

    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awcache = CACHE_DEFAULT;
    assign bus.axi_awprot  = PROT_DEFAULT;
    assign bus.axi_awlock  = LOCK_DEFAULT;
    assign bus.axi_awburst = BURST_INCR;
    assign bus.axi_awlen   = LEN_SINGLE;
    assign bus.axi_awsize  = axi_size(DW);
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = wmask_q;
    assign bus.axi_wlast   = 1'b1;
    assign bus.axi_bready  = bready_q;

endmodule

// File: tb/tb_n101_expl_axi_mst.sv
// Scoreboard bench for n101_expl_axi_mst: directed commands push expected
// responses; a negedge monitor pops and compares each response handshake.
module tb_n101_expl_axi_mst;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            launch;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];

    // Slave model: mode 0 mimics the coupled example slave, mode 1 is hand-driven.
    int   mode = 0;
    logic m_arready = 1'b0, m_rvalid = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;

    n101_expl_axi_mst_if #(.AW(AW), .DW(DW)) bus ();

    n101_expl_axi_mst #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.axi_arready = m_arready;
        bus.axi_rvalid  = m_rvalid;
        bus.axi_awready = m_awready;
        bus.axi_wready  = m_wready;
        bus.axi_bvalid  = m_bvalid;
        if (mode == 0) begin
            bus.axi_arready = bus.axi_rready;
            bus.axi_rvalid  = bus.axi_arvalid;
            bus.axi_awready = bus.axi_bready;
            bus.axi_wready  = bus.axi_bready;
            bus.axi_bvalid  = bus.axi_wvalid;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] wm, input logic [DW-1:0] er, input logic ee,
                         input int lat, output int launch);
        int budget = 0;
        while (!bus.cmd_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_wmask = wm;
        launch = cyc;
        q.push_back('{er, ee, lat, cyc});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((q.size() != 0 || !bus.cmd_ready) && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("idle_wait_queue_empty", q.size(), 0);
    endtask

    // Monitor: latency on rsp_valid rise, payload every valid cycle, quiet bus in RSP.
    initial begin : monitor
        logic prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("rsp_without_command", 1, 0);
                end else begin
                    if (!prev_valid && q[0].lat >= 0)
                        check("rsp_latency", cyc - q[0].launch, q[0].lat);
                    check("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                    check("rsp_err", bus.rsp_err, q[0].err);
                    check("no_axi_valid_in_rsp", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid}, 0);
                    check("cmd_ready_low_in_rsp", bus.cmd_ready, 0);
                    if (bus.rsp_ready) void'(q.pop_front());
                end
            end
            prev_valid = (bus.rsp_valid === 1'b1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int l1, l2, l3;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wmask = '0;
        bus.rsp_ready = 1'b1;
        bus.axi_rdata = '0;
        bus.axi_rresp = 2'b00;
        bus.axi_rlast = 1'b1;
        bus.axi_bresp = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_valids", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid}, 0);
        check("reset_readies", {bus.axi_rready, bus.axi_bready}, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Coupled read.
        issue(1'b1, 32'h8000_0010, '0, '0, 32'h0, 1'b0, 2, l1);
        @(negedge clk);
        check("rd_arvalid", bus.axi_arvalid, 1);
        check("rd_rready", bus.axi_rready, 1);
        check("rd_araddr", bus.axi_araddr, 32'h8000_0010);
        check("rd_arlen", bus.axi_arlen, 0);
        check("rd_arsize", bus.axi_arsize, 3'b010);
        check("rd_arburst", bus.axi_arburst, 2'b01);
        check("rd_cache_prot_lock", {bus.axi_arcache, bus.axi_arprot, bus.axi_arlock}, 0);
        wait_idle();

        // Coupled write; slave rdata must not leak into a write response.
        bus.axi_rdata = 32'hCAFE_F00D;
        issue(1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 2, l1);
        @(negedge clk);
        check("wr_awvalid", bus.axi_awvalid, 1);
        check("wr_wvalid", bus.axi_wvalid, 1);
        check("wr_bready", bus.axi_bready, 1);
        check("wr_awaddr", bus.axi_awaddr, 32'h1000_0004);
        check("wr_wdata", bus.axi_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", bus.axi_wstrb, 4'b0011);
        check("wr_wlast", bus.axi_wlast, 1);
        check("wr_aw_attr", {bus.axi_awlen, bus.axi_awsize, bus.axi_awburst}, {4'h0, 3'b010, 2'b01});
        wait_idle();
        bus.axi_rdata = '0;

        // Decoupled write: W at cycle 1, AW at cycle 4, B at cycle 5, rsp at cycle 6.
        mode = 1; m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0;
        issue(1'b0, 32'h2000_0008, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 6, l1);
        @(negedge clk);
        check("dec_c1_valids", {bus.axi_awvalid, bus.axi_wvalid}, 2'b11);
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("dec_awvalid_held", bus.axi_awvalid, 1);
            check("dec_awaddr_stable", bus.axi_awaddr, 32'h2000_0008);
            check("dec_wvalid_dropped", bus.axi_wvalid, 0);
        end
        @(posedge clk); #1;
        m_awready = 1'b1;
        @(negedge clk);
        check("dec_c4_awvalid", bus.axi_awvalid, 1);
        @(posedge clk); #1;
        m_awready = 1'b0; m_bvalid = 1'b1;
        @(negedge clk);
        check("dec_c5_awvalid_low", bus.axi_awvalid, 0);
        check("dec_c5_no_rsp_before_b", bus.rsp_valid, 0);
        check("dec_c5_bready", bus.axi_bready, 1);
        @(posedge clk); #1;
        m_bvalid = 1'b0; m_wready = 1'b0;
        wait_idle();
        mode = 0;

        // Error responses.
        bus.axi_bresp = 2'b10;
        issue(1'b0, 32'h3000_0000, 32'h0000_0055, 4'hF, 32'h0, 1'b1, 2, l1);
        wait_idle();
        bus.axi_bresp = 2'b00;
        bus.axi_rresp = 2'b11;
        bus.axi_rdata = 32'h1234_5678;
        issue(1'b1, 32'h3000_0010, '0, '0, 32'h1234_5678, 1'b1, 2, l1);
        wait_idle();
        bus.axi_rresp = 2'b00;

        // Response back-pressure.
        bus.rsp_ready = 1'b0;
        bus.axi_rdata = 32'h0BAD_CAFE;
        issue(1'b1, 32'h0000_0040, '0, '0, 32'h0BAD_CAFE, 1'b0, 2, l1);
        begin
            int budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (bus.rsp_valid !== 1'b1 && budget < 20);
        end
        check("stall_rsp_valid_seen", bus.rsp_valid, 1);
        repeat (4) @(negedge clk);
        check("stall_rsp_still_valid", bus.rsp_valid, 1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_cmd_ready", bus.cmd_ready, 1);
        check("stall_release_rsp_valid", bus.rsp_valid, 0);

        // Back-to-back reads, 3 cycles apart.
        bus.axi_rdata = 32'h0000_0011;
        issue(1'b1, 32'h0000_0100, '0, '0, 32'h0000_0011, 1'b0, 2, l1);
        issue(1'b1, 32'h0000_0104, '0, '0, 32'h0000_0011, 1'b0, 2, l2);
        issue(1'b1, 32'h0000_0108, '0, '0, 32'h0000_0011, 1'b0, 2, l3);
        check("b2b_spacing_1", l2 - l1, 3);
        check("b2b_spacing_2", l3 - l2, 3);
        wait_idle();

        // Reset while arvalid is outstanding.
        mode = 1; m_arready = 1'b0; m_rvalid = 1'b0;
        issue(1'b1, 32'h0000_0050, '0, '0, 32'h0, 1'b0, -1, l1);
        @(negedge clk);
        check("rst_pre_arvalid", bus.axi_arvalid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_arvalid", bus.axi_arvalid, 0);
        check("rst_rready", bus.axi_rready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        bus.axi_rdata = 32'h0000_0077;
        @(posedge clk); #1;
        issue(1'b1, 32'h0000_0060, '0, '0, 32'h0000_0077, 1'b0, 2, l1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
